// File: rtl/core_global_regs.sv
// core_global_regs: bus_clk settings registers, readback mux, lock monitor, time sync.
// Define LOCK_CNT_EN to build the per-lock saturating loss counters.
module core_global_regs #(
  parameter int          NUM_RADIOS     = 2,
  parameter int          NUM_LOCKS      = 2,
  parameter logic [7:0]  SR_BASE        = 8'h00,
  parameter int          COMPAT_MAJOR   = 16,
  parameter int          COMPAT_MINOR   = 0,
  parameter logic [31:0] GIT_HASH       = 32'h0,
  parameter int          SYNC_LEN       = 4,
  parameter int          LOCK_CNT_WIDTH = 16
) (
  input  logic                    bus_clk,
  input  logic                    bus_rst_n,
  input  logic                    set_stb,
  input  logic [7:0]              set_addr,
  input  logic [31:0]             set_data,
  output logic [31:0]             rb_data,
  input  logic [NUM_LOCKS-1:0]    lock_signals,
  input  logic [3:0]              tcxo_status,
  output logic [1:0]              pps_select,
  output logic                    mimo,
  output logic                    codec_arst,
  output logic [31:0]             misc_out,
  output logic [7:0]              xb_local_addr,
  output logic [32*NUM_RADIOS-1:0] radio_ctrl,
  output logic                    time_sync,
  output logic [NUM_LOCKS-1:0]    lock_state
);
  localparam int          SW        = $clog2(SYNC_LEN + 1);
  localparam logic [SW-1:0] SYNC_LOAD = SW'(SYNC_LEN);
  localparam logic [7:0]  MAJ       = 8'(COMPAT_MAJOR);
  localparam logic [7:0]  MIN       = 8'(COMPAT_MINOR);
  localparam logic [31:0] BAD       = 32'hDEADBEEF;

  logic wr_rb, wr_misc, wr_sync, wr_clr, wr_test, wr_xb;

  assign wr_rb   = set_stb && (set_addr == SR_BASE + 8'h00);
  assign wr_misc = set_stb && (set_addr == SR_BASE + 8'h04);
  assign wr_sync = set_stb && (set_addr == SR_BASE + 8'h08);
  assign wr_clr  = set_stb && (set_addr == SR_BASE + 8'h0C);
  assign wr_test = set_stb && (set_addr == SR_BASE + 8'h1C);
  assign wr_xb   = set_stb && (set_addr == SR_BASE + 8'h20);

  logic [4:0]                rb_addr;
  logic [31:0]               misc;
  logic [31:0]               test;
  logic [7:0]                xb;
  logic [32*NUM_RADIOS-1:0]  radio;
  logic [SW-1:0]             sync_cnt;
  logic [NUM_LOCKS-1:0]      sync1, sync2, prev;
  logic [NUM_LOCKS-1:0]      sticky, fall, clr;
  logic [31:0]               rb_next;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      rb_addr <= '0;
      misc    <= 32'h2;
      test    <= '0;
      xb      <= 8'd40;
    end else begin
      if (wr_rb)   rb_addr <= set_data[4:0];
      if (wr_misc) misc    <= set_data;
      if (wr_test) test    <= set_data;
      if (wr_xb)   xb      <= set_data[7:0];
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      radio <= '0;
    end else begin
      for (int i = 0; i < NUM_RADIOS; i++)
        if (set_stb && set_addr == SR_BASE + 8'h40 + 8'(4 * i))
          radio[32*i +: 32] <= set_data;
    end
  end

  // Retrigger simply reloads, so the pulse always ends SYNC_LEN after the last write.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)
      sync_cnt <= '0;
    else if (wr_sync)
      sync_cnt <= SYNC_LOAD;
    else if (sync_cnt != '0)
      sync_cnt <= sync_cnt - SW'(1);
  end

  assign fall = prev & ~sync2;
  assign clr  = wr_clr ? set_data[NUM_LOCKS-1:0] : '0;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      prev   <= '0;
      sticky <= '0;
    end else begin
      sync1  <= lock_signals;
      sync2  <= sync1;
      prev   <= sync2;
      sticky <= (sticky & ~clr) | fall;
    end
  end

`ifdef LOCK_CNT_EN
  logic [LOCK_CNT_WIDTH-1:0] lock_cnt [NUM_LOCKS];

  // A loss coinciding with a clear counts as the first loss after the clear.
  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      for (int i = 0; i < NUM_LOCKS; i++)
        lock_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LOCKS; i++) begin
        if (fall[i]) begin
          if (clr[i])
            lock_cnt[i] <= LOCK_CNT_WIDTH'(1);
          else if (lock_cnt[i] != '1)
            lock_cnt[i] <= lock_cnt[i] + LOCK_CNT_WIDTH'(1);
        end else if (clr[i]) begin
          lock_cnt[i] <= '0;
        end
      end
    end
  end
`else
  logic [31:0] unused_cnt_width;
  assign unused_cnt_width = 32'(LOCK_CNT_WIDTH);
`endif

  always_comb begin
    rb_next = BAD;
    case (rb_addr)
      5'd1:    rb_next = {26'd0, tcxo_status, misc[1:0]};
      5'd2:    rb_next = {8'hAC, 8'h00, MAJ, MIN};
      5'd3:    rb_next = GIT_HASH;
      5'd4:    rb_next = {16'd0, 8'(sticky), 8'(sync2)};
      5'd6:    rb_next = {16'(NUM_RADIOS), 16'(NUM_LOCKS)};
      5'd24:   rb_next = test;
      default: rb_next = BAD;
    endcase
`ifdef LOCK_CNT_EN
    for (int i = 0; i < NUM_LOCKS; i++)
      if (rb_addr == 5'(8 + i))
        rb_next = 32'(lock_cnt[i]);
`endif
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)
      rb_data <= BAD;
    else
      rb_data <= rb_next;
  end

  assign misc_out      = misc;
  assign pps_select    = misc[1:0];
  assign mimo          = misc[2];
  assign codec_arst    = misc[3];
  assign xb_local_addr = xb;
  assign radio_ctrl    = radio;
  assign time_sync     = (sync_cnt != '0);
  assign lock_state    = sync2;

endmodule

// File: tb/tb_core_global_regs.sv
// tb_core_global_regs: directed plus random settings traffic against a
// history-based reference model of the register block.
module tb_core_global_regs;
  localparam int          NR   = 2;
  localparam int          NL   = 2;
  localparam int          SL   = 4;
  localparam int          CW   = 2;
  localparam logic [7:0]  BASE = 8'h00;
  localparam logic [31:0] HASH = 32'hC0FFEE42;
  localparam logic [31:0] BAD  = 32'hDEADBEEF;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          stb   = 1'b0;
  logic [7:0]    addr  = '0;
  logic [31:0]   data  = '0;
  logic [NL-1:0] locks = '0;
  logic [3:0]    tcxo  = 4'h5;

  logic [31:0]      rb_data;
  logic [1:0]       pps_select;
  logic             mimo;
  logic             codec_arst;
  logic [31:0]      misc_out;
  logic [7:0]       xb_local_addr;
  logic [32*NR-1:0] radio_ctrl;
  logic             time_sync;
  logic [NL-1:0]    lock_state;

  always #5 clk = ~clk;

  core_global_regs #(
    .NUM_RADIOS(NR), .NUM_LOCKS(NL), .SR_BASE(BASE),
    .COMPAT_MAJOR(16), .COMPAT_MINOR(0), .GIT_HASH(HASH),
    .SYNC_LEN(SL), .LOCK_CNT_WIDTH(CW)
  ) dut (
    .bus_clk(clk), .bus_rst_n(rst_n),
    .set_stb(stb), .set_addr(addr), .set_data(data),
    .rb_data(rb_data), .lock_signals(locks), .tcxo_status(tcxo),
    .pps_select(pps_select), .mimo(mimo), .codec_arst(codec_arst),
    .misc_out(misc_out), .xb_local_addr(xb_local_addr),
    .radio_ctrl(radio_ctrl), .time_sync(time_sync),
    .lock_state(lock_state)
  );

  int n_vec = 0;
  int n_bad = 0;
  int ts_hi = 0;

  logic [4:0]    m_rb_addr;
  logic [31:0]   m_misc, m_test, m_rb;
  logic [7:0]    m_xb;
  logic [31:0]   m_radio [NR];
  logic [NL-1:0] m_sticky;
  int            m_cnt [NL];
  int            m_cyc, m_last;
  logic [NL-1:0] m_hist [$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rb();
    logic [NL-1:0] ls;
    int a;
    ls = m_hist[m_hist.size() - 2];
    a  = int'(m_rb_addr);
    if (a == 1)  return {26'd0, tcxo, m_misc[1:0]};
    if (a == 2)  return {8'hAC, 8'h00, 8'd16, 8'd0};
    if (a == 3)  return HASH;
    if (a == 4)  return {16'd0, 8'(m_sticky), 8'(ls)};
    if (a == 6)  return {16'(NR), 16'(NL)};
    if (a == 24) return m_test;
`ifdef LOCK_CNT_EN
    if (a >= 8 && a < 8 + NL) return 32'(m_cnt[a-8]);
`endif
    return BAD;
  endfunction

  task automatic model_reset();
    m_rb_addr = '0;
    m_misc    = 32'h2;
    m_test    = '0;
    m_xb      = 8'd40;
    m_rb      = BAD;
    m_sticky  = '0;
    m_cyc     = 0;
    m_last    = -100;
    for (int i = 0; i < NR; i++) m_radio[i] = '0;
    for (int i = 0; i < NL; i++) m_cnt[i] = 0;
    m_hist.delete();
    repeat (3) m_hist.push_back('0);
  endtask

  task automatic model_edge();
    logic [31:0]   rb;
    logic [NL-1:0] b1, b2, fall, clr;
    logic [7:0]    off;
    int            e;
    int            top;
    e    = m_cyc;
    top  = (1 << CW) - 1;
    rb   = model_rb();
    b1   = m_hist[m_hist.size() - 2];
    b2   = m_hist[m_hist.size() - 3];
    fall = b2 & ~b1;
    off  = addr - BASE;
    clr  = (stb && off == 8'h0C) ? data[NL-1:0] : '0;
    for (int i = 0; i < NL; i++) begin
      if (fall[i]) begin
        m_sticky[i] = 1'b1;
        m_cnt[i] = clr[i] ? 1 : ((m_cnt[i] >= top) ? top : m_cnt[i] + 1);
      end else if (clr[i]) begin
        m_sticky[i] = 1'b0;
        m_cnt[i] = 0;
      end
    end
    if (stb) begin
      if (off == 8'h00) m_rb_addr = data[4:0];
      if (off == 8'h04) m_misc = data;
      if (off == 8'h08) m_last = e;
      if (off == 8'h1C) m_test = data;
      if (off == 8'h20) m_xb = data[7:0];
      if (off >= 8'h40 && int'(off) < 8'h40 + 4 * NR && off[1:0] == 2'b00)
        m_radio[int'(off - 8'h40) / 4] = data;
    end
    m_hist.push_back(locks);
    if (m_hist.size() > 4) void'(m_hist.pop_front());
    m_rb = rb;
    m_cyc++;
  endtask

  task automatic check_all();
    logic [63:0] rexp;
    int d;
    rexp = '0;
    for (int i = 0; i < NR; i++) rexp[32*i +: 32] = m_radio[i];
    d = m_cyc - 1 - m_last;
    chk("rb_data", rb_data, m_rb);
    chk("misc_out", misc_out, m_misc);
    chk("pps_select", pps_select, m_misc[1:0]);
    chk("mimo", mimo, m_misc[2]);
    chk("codec_arst", codec_arst, m_misc[3]);
    chk("xb_local", xb_local_addr, m_xb);
    chk("radio_ctrl", radio_ctrl, rexp);
    chk("time_sync", time_sync, (d >= 0 && d < SL));
    chk("lock_state", lock_state, m_hist[m_hist.size() - 2]);
    if (time_sync) ts_hi++;
  endtask

  task automatic cyc(input logic s, input logic [7:0] a, input logic [31:0] d);
    stb  = s;
    addr = a;
    data = d;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    stb = 1'b0;
  endtask

  task automatic rd(input logic [4:0] ra);
    cyc(1'b1, BASE, 32'(ra));
    cyc(1'b0, 8'h0, 32'h0);
  endtask

  task automatic drop1();
    locks[1] = 1'b1;
    repeat (3) cyc(1'b0, 8'h0, 32'h0);
    locks[1] = 1'b0;
    repeat (3) cyc(1'b0, 8'h0, 32'h0);
  endtask

  logic [7:0] offs [12] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h1C, 8'h20,
                            8'h40, 8'h44, 8'h48, 8'h10, 8'h18, 8'hFC};

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rb", rb_data, BAD);
    chk("rst_misc", misc_out, 32'h2);
    chk("rst_xb", xb_local_addr, 8'd40);
    chk("rst_ts", time_sync, 1'b0);
    chk("rst_radio", radio_ctrl, 64'h0);
    rst_n = 1'b1;

    rd(5'd2);
    chk("compat", rb_data, 32'hAC001000);
    rd(5'd4);
    chk("lock_rb0", rb_data, 32'h0);
    rd(5'd6);
    chk("counts", rb_data, 32'h00020002);

    cyc(1'b1, BASE + 8'h44, 32'hA5A50001);
    chk("radio1", radio_ctrl[63:32], 32'hA5A50001);
    chk("radio0", radio_ctrl[31:0], 32'h0);

    ts_hi = 0;
    cyc(1'b1, BASE + 8'h08, 32'h0);
    cyc(1'b0, 8'h0, 32'h0);
    cyc(1'b1, BASE + 8'h08, 32'h0);
    repeat (8) cyc(1'b0, 8'h0, 32'h0);
    chk("ts_len", 64'(ts_hi), 64'd6);

    locks[0] = 1'b1;
    repeat (3) drop1();
    rd(5'd4);
    chk("sticky3", rb_data, 32'h00000201);
    rd(5'd9);
`ifdef LOCK_CNT_EN
    chk("cnt3", rb_data, 32'd3);
`else
    chk("cnt_off", rb_data, BAD);
`endif

    locks[1] = 1'b1;
    repeat (3) cyc(1'b0, 8'h0, 32'h0);
    locks[1] = 1'b0;
    cyc(1'b0, 8'h0, 32'h0);
    cyc(1'b0, 8'h0, 32'h0);
    cyc(1'b1, BASE + 8'h0C, 32'h2);
    rd(5'd4);
    chk("clr_edge", rb_data, 32'h00000201);
    rd(5'd9);
`ifdef LOCK_CNT_EN
    chk("cnt_clr_edge", rb_data, 32'd1);
`else
    chk("cnt_off2", rb_data, BAD);
`endif

    cyc(1'b1, BASE + 8'h0C, 32'h3);
    rd(5'd4);
    chk("cleared", rb_data, 32'h00000001);
    repeat (5) drop1();
    rd(5'd9);
`ifdef LOCK_CNT_EN
    chk("cnt_sat", rb_data, 32'd3);
`else
    chk("cnt_off3", rb_data, BAD);
`endif

    repeat (500) begin
      logic [7:0]  o;
      logic [31:0] d;
      o = offs[$urandom_range(0, 11)];
      d = (o == 8'h00) ? 32'($urandom_range(0, 31)) : $urandom;
      for (int j = 0; j < NL; j++)
        if ($urandom_range(0, 7) == 0) locks[j] = ~locks[j];
      if ($urandom_range(0, 31) == 0) tcxo = 4'($urandom);
      cyc($urandom_range(0, 2) == 0, BASE + o, d);
    end

    cyc(1'b1, BASE, 32'd31);
    cyc(1'b1, BASE + 8'h08, 32'h0);
    cyc(1'b0, 8'h0, 32'h0);
    chk("ts_pre_rst", time_sync, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("ts_in_rst", time_sync, 1'b0);
    chk("rb_in_rst", rb_data, BAD);
    chk("misc_in_rst", misc_out, 32'h2);
    chk("ls_in_rst", lock_state, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    cyc(1'b0, 8'h0, 32'h0);
    cyc(1'b0, 8'h0, 32'h0);
    chk("rb_after_rst", rb_data, BAD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_global_regs.md
# core_global_regs

Parametrised global control/status register block for multi-radio USRP cores. It replaces the fixed inline settings registers and readback mux of the current two-radio core. It adds:
- NUM_RADIOS per-radio control words
- NUM_LOCKS synchronised PLL lock inputs with sticky loss flags and optional saturating loss counters
- a counter-timed, retriggerable time-sync pulse

It sits on the bus_clk settings bus between the host register interface and the crossbar/radio instances.

## Interface
Parameters:
- NUM_RADIOS, 2, number of radio control words (1..16)
- NUM_LOCKS, 2, number of lock inputs (1..8)
- SR_BASE, 8'h00, base settings address
- COMPAT_MAJOR, 16, compat readback byte 1
- COMPAT_MINOR, 0, compat readback byte 0
- GIT_HASH, 32'h0, githash readback value
- SYNC_LEN, 4, time_sync pulse length in cycles (≥1)
- LOCK_CNT_WIDTH, 16, loss counter width (1..32)

Ports:
- bus_clk  in  1  sole clock
- bus_rst_n  in  1  reset, asynchronous, active-low
- set_stb  in  1  settings write strobe
- set_addr  in  8  settings address
- set_data  in  32  settings data
- rb_data  out  32  registered readback
- lock_signals  in  NUM_LOCKS  asynchronous PLL lock inputs
- tcxo_status  in  4  status bits, quasi-static
- pps_select  out  2  misc[1:0]
- mimo  out  1  misc[2]
- codec_arst  out  1  misc[3]
- misc_out  out  32  full MISC register
- xb_local_addr  out  8  crossbar local address
- radio_ctrl  out  32*NUM_RADIOS  per-radio control words, radio i at [32i+31:32i]
- time_sync  out  1  timed sync pulse
- lock_state  out  NUM_LOCKS  synchronised lock levels

## Operation
Write map. A register is written when set_stb=1 and set_addr equals SR_BASE plus the offset:
- +0x00 READBACK: rb_addr = set_data[4:0]
- +0x04 MISC: 32 bits
- +0x08 TIME_SYNC: any data; starts or restarts the pulse
- +0x0C LOCK_CLEAR: set_data[NUM_LOCKS-1:0] is a clear mask for sticky flags and counters
- +0x1C TEST: 32 bits
- +0x20 XB_LOCAL: 8 bits
- +0x40+4i RADIO_CTRL i: 32 bits, for i < NUM_RADIOS

Unmapped addresses are ignored.

Readback by rb_addr:
- 1: {26'd0, tcxo_status, pps_select}
- 2: {8'hAC, 8'h00, COMPAT_MAJOR[7:0], COMPAT_MINOR[7:0]}
- 3: GIT_HASH
- 4: {16'd0, sticky zero-extended to 8, lock_state zero-extended to 8}
- 6: {16'd NUM_RADIOS, 16'd NUM_LOCKS}
- 8+i: loss counter i zero-extended, for i < NUM_LOCKS
- 24: TEST
- any other value: 32'hDEADBEEF

Lock path, per bit:
- Two-flop synchroniser produces lock_state.
- A third flop holds the previous level.
- A falling edge (previous=1, current=0) sets the sticky flag and increments the counter.
- The counter saturates at all-ones.
- LOCK_CLEAR zeroes the flag and counter of each masked bit.
- A clear and a falling edge in the same cycle leave the flag at 1 and the counter at 1.

Time sync:
- A down-counter loads SYNC_LEN on a TIME_SYNC write.
- time_sync = (counter != 0); the counter decrements each cycle while non-zero.
- A write during an active pulse reloads the counter, extending the pulse to SYNC_LEN cycles from that write.

## Timing
- Values after reset:
  - misc_out = 32'h2, so pps_select = 2'b10, mimo = 0, codec_arst = 0
  - xb_local_addr = 8'd40
  - radio_ctrl, TEST and rb_addr = 0
  - rb_data = 32'hDEADBEEF
  - time_sync, lock_state, sticky flags and counters = 0
- A register write is visible on its output in the cycle after set_stb.
- rb_data is registered. It reflects rb_addr and its sources as of the previous edge, so a READBACK write shows on rb_data 2 cycles after set_stb.
- lock_state follows lock_signals after 2 edges. The sticky flag and counter update 1 edge after lock_state falls.
- time_sync rises 1 cycle after the TIME_SYNC strobe and stays high for exactly SYNC_LEN cycles unless retriggered.
- Asserting bus_rst_n low at any point, including mid-pulse or mid-edge, immediately forces all the values listed above. Sequential state resumes on the first edge after release.

## Configuration
- Macro LOCK_CNT_EN.
- Defined: loss counters are built and readback 8+i returns counter i.
- Undefined: no counters; readback 8+i returns 32'hDEADBEEF; sticky flags and LOCK_CLEAR behave identically.

## Test plan
- Reset, then read rb_addr 2, 4, 6: expect 32'hAC001000, 32'h0, 32'h00020002; misc_out = 32'h2; xb_local_addr = 40.
- Write RADIO_CTRL1 (addr 0x44) = 32'hA5A5_0001: radio_ctrl[63:32] = 32'hA5A5_0001 in the next cycle; radio_ctrl[31:0] remains 0.
- Write TIME_SYNC, then write TIME_SYNC again 2 cycles later, with SYNC_LEN=4: time_sync is high for 6 consecutive cycles.
- Toggle lock_signals[1] 1→0 three times: rb_addr 4 = 32'h0000_0201 with lock0=1 and lock1=0; rb_addr 9 = 3 (LOCK_CNT_EN). Write LOCK_CLEAR = 2 coincident with a fourth lock1 falling edge: sticky[1] = 1, counter1 = 1.
- LOCK_CNT_WIDTH=2, with five lock1 loss events: counter1 reads 3. With LOCK_CNT_EN undefined, rb_addr 9 reads 32'hDEADBEEF.
- Drop bus_rst_n for one cycle mid-pulse, and set rb_addr = 31: time_sync drops immediately, and after release rb_data = 32'hDEADBEEF.
